// File: rtl/riscv_pkg.sv
// Types and constants shared by the RV32I pipeline stages (fetch state, bubble encoding, opcodes).
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_BUBBLE = 32'h0;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    StA0,
    StA1,
    StA2,
    StA3,
    StW,
    StHold
  } fetch_state_e;

  // Redirect targets are word aligned; the sum wraps at 2^32.
  function automatic logic [XLEN-1:0] fetch_target(input logic [XLEN-1:0] base,
                                                   input logic [XLEN-1:0] off);
    logic [XLEN-1:0] sum;
    sum = base + off;
    return {sum[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// Fetch-stage bus: byte-wide memory read port plus the decode-side handshake.
interface ifetch_if;
  import riscv_pkg::*;

  logic [XLEN-1:0] mem_a;
  logic            mem_rd;
  logic [7:0]      mem_din;

  logic            stall;
  logic            id_if_pce;
  logic [XLEN-1:0] id_if_pc;
  logic [XLEN-1:0] id_if_off;

  logic [XLEN-1:0] if_is;
  logic [XLEN-1:0] if_pc;
  logic            if_valid;

  modport master (
    output mem_a, mem_rd, if_is, if_pc, if_valid,
    input  mem_din, stall, id_if_pce, id_if_pc, id_if_off
  );

  modport slave (
    input  mem_a, mem_rd, if_is, if_pc, if_valid,
    output mem_din, stall, id_if_pce, id_if_pc, id_if_off
  );

endinterface

// File: rtl/ifetch_asm.sv
// Byte-lane assembler: collects the four little-endian read bytes of one instruction word.
module ifetch_asm
  import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  fetch_state_e    state,
    input  logic            clr,
    input  logic [7:0]      mem_din,
    output logic [XLEN-1:0] word
);

    logic [XLEN-1:0] buf_q, buf_d;

    // Each byte arrives one cycle after its read strobe, i.e. in the following state.
    always_comb begin
        buf_d = buf_q;
        if (clr) begin
            buf_d = '0;
        end else begin
            case (state)
                StA1:    buf_d[7:0]   = mem_din;
                StA2:    buf_d[15:8]  = mem_din;
                StA3:    buf_d[23:16] = mem_din;
                StW:     buf_d[31:24] = mem_din;
                default: buf_d = buf_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

    assign word = buf_q;

endmodule

// File: rtl/ifetch.sv
// RV32I instruction fetch: four byte reads per word, stall hold, and redirect with one bubble.
module ifetch
  import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
    input logic      clk,
    input logic      rst_n,
    ifetch_if.master bus
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            full_q, full_d;
    logic [XLEN-1:0] is_q, is_d;
    logic [XLEN-1:0] ipc_q, ipc_d;
    logic            valid_q, valid_d;

    logic [XLEN-1:0] asm_word;
    logic [XLEN-1:0] word;
    logic            asm_clr;
    logic            present;
    logic [XLEN-1:0] mem_a;
    logic            mem_rd;

    ifetch_asm u_asm (
        .clk     (clk),
        .rst_n   (rst_n),
        .state   (state_q),
        .clr     (asm_clr),
        .mem_din (bus.mem_din),
        .word    (asm_word)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        full_d  = full_q;
        is_d    = is_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        asm_clr = 1'b0;
        present = 1'b0;
        word    = asm_word;

        case (state_q)
            StA0: state_d = StA1;
            StA1: state_d = StA2;
            StA2: state_d = StA3;
            StA3: state_d = StW;
            StW: begin
                // Top byte is still on mem_din; bypass it so W can present directly.
                word = {bus.mem_din, asm_word[23:0]};
                if (bus.stall) begin
                    full_d  = 1'b1;
                    state_d = StHold;
                end else begin
                    present = 1'b1;
                    state_d = StA0;
                end
            end
            StHold: begin
                if (!bus.stall) begin
                    present = full_q;
                    full_d  = 1'b0;
                    state_d = StA0;
                end
            end
            default: state_d = StA0;
        endcase

        if (present) begin
            is_d    = word;
            ipc_d   = pc_q + 32'd4;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
        end else if (!bus.stall) begin
            is_d    = NOP_BUBBLE;
            valid_d = 1'b0;
        end

        // Redirect overrides everything, including a word completing this cycle.
        if (bus.id_if_pce) begin
            pc_d    = fetch_target(bus.id_if_off, bus.id_if_pc);
            state_d = StA0;
            full_d  = 1'b0;
            asm_clr = 1'b1;
            is_d    = NOP_BUBBLE;
            valid_d = 1'b0;
            ipc_d   = ipc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StA0;
            pc_q    <= RESET_PC;
            full_q  <= 1'b0;
            is_q    <= NOP_BUBBLE;
            ipc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            full_q  <= full_d;
            is_q    <= is_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
        end
    end

    // Memory port is Moore on the state; held quiet while reset is asserted.
    always_comb begin
        mem_a  = '0;
        mem_rd = 1'b0;
        if (rst_n) begin
            case (state_q)
                StA0: begin mem_a = pc_q;          mem_rd = 1'b1; end
                StA1: begin mem_a = pc_q + 32'd1;  mem_rd = 1'b1; end
                StA2: begin mem_a = pc_q + 32'd2;  mem_rd = 1'b1; end
                StA3: begin mem_a = pc_q + 32'd3;  mem_rd = 1'b1; end
                default: begin mem_a = '0;         mem_rd = 1'b0; end
            endcase
        end
    end

    assign bus.mem_a    = mem_a;
    assign bus.mem_rd   = mem_rd;
    assign bus.if_is    = is_q;
    assign bus.if_pc    = ipc_q;
    assign bus.if_valid = valid_q;

endmodule
